// File: rtl/alu_arbiter.sv
// Shares one registered-output ALU between the pipeline (r0, fixed priority) and a
// secondary requester (r1), with starvation-bounded r1 access and flush cancellation.
module alu_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CTRL_W     = 5,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [WIDTH-1:0]  r0_a,
    input  logic [WIDTH-1:0]  r0_b,
    input  logic [CTRL_W-1:0] r0_ctrl,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [WIDTH-1:0]  r1_a,
    input  logic [WIDTH-1:0]  r1_b,
    input  logic [CTRL_W-1:0] r1_ctrl,
    input  logic              flush,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [3:0]        alu_flags,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [WIDTH-1:0]  rdata,
    output logic [3:0]        rflags
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       inflight_v_q, inflight_v_d;
    logic       inflight_id_q, inflight_id_d;
    logic       force_r1;
    logic       grant_r0, grant_r1;

    assign force_r1 = (starve_cnt_q == StarveMax);

    always_comb begin
        grant_r0 = 1'b0;
        grant_r1 = 1'b0;
        if (!reset) begin
            if (force_r1 && r1_valid) begin
                grant_r1 = 1'b1;
            end else if (r0_valid && !flush) begin
                grant_r0 = 1'b1;
            end else if (r1_valid) begin
                grant_r1 = 1'b1;
            end
        end
    end

    assign r0_ready = grant_r0;
    assign r1_ready = grant_r1;

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (grant_r0) begin
            alu_a    = r0_a;
            alu_b    = r0_b;
            alu_ctrl = r0_ctrl;
        end else if (grant_r1) begin
            alu_a    = r1_a;
            alu_b    = r1_b;
            alu_ctrl = r1_ctrl;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_r1) begin
            starve_cnt_d = '0;
        end else if (grant_r0 && r1_valid && (starve_cnt_q != StarveMax)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_comb begin
        inflight_v_d  = grant_r0 | grant_r1;
        inflight_id_d = grant_r1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q  <= '0;
            inflight_v_q  <= 1'b0;
            inflight_id_q <= 1'b0;
        end else begin
            starve_cnt_q  <= starve_cnt_d;
            inflight_v_q  <= inflight_v_d;
            inflight_id_q <= inflight_id_d;
        end
    end

    // Reset gates responses so an op issued just before reset never answers.
    always_comb begin
        r0_rvalid = inflight_v_q && !inflight_id_q && !flush && !reset;
        r1_rvalid = inflight_v_q && inflight_id_q && !reset;
        rdata     = '0;
        rflags    = '0;
        if (r0_rvalid || r1_rvalid) begin
            rdata  = alu_result;
            rflags = alu_flags;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU answers each issue one cycle later
// and a small grant model predicts readies, operand muxing and responses.
module tb_alu_arbiter;

    localparam int unsigned Width     = 32;
    localparam int unsigned CtrlW     = 5;
    localparam int unsigned StarveMax = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              r0_valid, r1_valid, flush;
    logic              r0_ready, r1_ready;
    logic [Width-1:0]  r0_a, r0_b, r1_a, r1_b;
    logic [CtrlW-1:0]  r0_ctrl, r1_ctrl;
    logic [Width-1:0]  alu_a, alu_b;
    logic [CtrlW-1:0]  alu_ctrl;
    logic [Width-1:0]  alu_result = '0;
    logic [3:0]        alu_flags = '0;
    logic              r0_rvalid, r1_rvalid;
    logic [Width-1:0]  rdata;
    logic [3:0]        rflags;

    alu_arbiter #(
        .WIDTH      (Width),
        .CTRL_W     (CtrlW),
        .STARVE_MAX (StarveMax)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .r0_valid   (r0_valid),
        .r0_ready   (r0_ready),
        .r0_a       (r0_a),
        .r0_b       (r0_b),
        .r0_ctrl    (r0_ctrl),
        .r1_valid   (r1_valid),
        .r1_ready   (r1_ready),
        .r1_a       (r1_a),
        .r1_b       (r1_b),
        .r1_ctrl    (r1_ctrl),
        .flush      (flush),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .r0_rvalid  (r0_rvalid),
        .r1_rvalid  (r1_rvalid),
        .rdata      (rdata),
        .rflags     (rflags)
    );

    always #5 clk = ~clk;

    // Returns {N,Z,C,V,result}; C is carry-out for add and not-borrow for sub.
    function automatic logic [35:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [4:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic        cy;
        logic        v;
        s  = '0;
        cy = 1'b0;
        v  = 1'b0;
        case (c)
            5'd0: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                cy = s[32];
                v  = (a[31] == b[31]) && (r[31] != a[31]);
            end
            5'd1: begin
                s  = {1'b0, a} - {1'b0, b};
                r  = s[31:0];
                cy = !s[32];
                v  = (a[31] != b[31]) && (r[31] != a[31]);
            end
            5'd2:    r = a & b;
            5'd3:    r = a | b;
            5'd4:    r = a ^ b;
            default: r = a;
        endcase
        return {r[31], (r == 32'd0), cy, v, r};
    endfunction

    always @(posedge clk) {alu_flags, alu_result} <= alu_ref(alu_a, alu_b, alu_ctrl);

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic [3:0]  flags;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_cnt;
    logic       last_g1;
    int         n_total = 0;
    int         n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [4:0] c0, input logic v1, input logic [31:0] a1,
                         input logic [31:0] b1, input logic [4:0] c1, input logic fl);
        r0_valid = v0; r0_a = a0; r0_b = b0; r0_ctrl = c0;
        r1_valid = v1; r1_a = a1; r1_b = b1; r1_ctrl = c1;
        flush    = fl;
    endtask

    // Checks one cycle against the model, then advances past the next rising edge.
    task automatic step();
        exp_t        e;
        logic        e0, e1, g0, g1, have;
        logic [35:0] res;
        #3;
        have = (sb.size() > 0);
        e0 = 1'b0;
        e1 = 1'b0;
        e  = '{id: 1'b0, data: '0, flags: '0};
        if (have) begin
            e  = sb.pop_front();
            e0 = !e.id && !flush && !reset;
            e1 = e.id && !reset;
        end
        check("r0_rvalid", 64'(r0_rvalid), 64'(e0));
        check("r1_rvalid", 64'(r1_rvalid), 64'(e1));
        check("rdata", 64'(rdata), (e0 || e1) ? 64'(e.data) : 64'd0);
        check("rflags", 64'(rflags), (e0 || e1) ? 64'(e.flags) : 64'd0);

        g1 = !reset && r1_valid && ((m_cnt == 4'(StarveMax)) || !(r0_valid && !flush));
        g0 = !reset && r0_valid && !flush && !g1;
        check("r0_ready", 64'(r0_ready), 64'(g0));
        check("r1_ready", 64'(r1_ready), 64'(g1));
        check("alu_a", 64'(alu_a), g0 ? 64'(r0_a) : (g1 ? 64'(r1_a) : 64'd0));
        check("alu_b", 64'(alu_b), g0 ? 64'(r0_b) : (g1 ? 64'(r1_b) : 64'd0));
        check("alu_ctrl", 64'(alu_ctrl), g0 ? 64'(r0_ctrl) : (g1 ? 64'(r1_ctrl) : 64'd0));
        check("starve_cnt", 64'(dut.starve_cnt_q), 64'(m_cnt));
        last_g1 = r1_ready;

        if (g0) begin
            res = alu_ref(r0_a, r0_b, r0_ctrl);
            sb.push_back('{id: 1'b0, data: res[31:0], flags: res[35:32]});
        end else if (g1) begin
            res = alu_ref(r1_a, r1_b, r1_ctrl);
            sb.push_back('{id: 1'b1, data: res[31:0], flags: res[35:32]});
        end
        if (reset || g1) m_cnt = '0;
        else if (g0 && r1_valid && (m_cnt != 4'(StarveMax))) m_cnt = m_cnt + 4'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] pat;
        m_cnt = '0;
        reset = 1'b1;
        drive(1'b1, 32'd9, 32'd9, 5'd0, 1'b1, 32'd8, 32'd8, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        // Requests held during reset must not be granted.
        step();
        step();
        reset = 1'b0;
        idle(2);

        // Basic r0 add: 5+7 -> 12, flags 0000.
        drive(1'b1, 32'd5, 32'd7, 5'd0, 1'b0, '0, '0, '0, 1'b0);
        step();
        idle(1);

        // Both continuously valid: r0 x4 then r1, repeating.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(i + 100), 32'(i), 5'd0, 1'b1, 32'(i * 3), 32'hFF, 5'd4, 1'b0);
            step();
            pat[i] = last_g1;
        end
        check("starve_pattern", 64'(pat), 64'h210);
        idle(1);

        // Flush in the response cycle of an r0 sub suppresses it.
        drive(1'b1, 32'd3, 32'd3, 5'd1, 1'b0, '0, '0, '0, 1'b0);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
        step();
        idle(1);

        // Build some starvation, then flush at issue hands the slot to r1.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'd1, 32'd2, 5'd0, 1'b1, 32'hF0, 32'h3C, 5'd2, 1'b0);
            step();
        end
        drive(1'b1, 32'd1, 32'd2, 5'd0, 1'b1, 32'hF0, 32'h3C, 5'd2, 1'b1);
        step();
        drive(1'b1, 32'd1, 32'd2, 5'd0, 1'b0, '0, '0, '0, 1'b1);
        step();
        idle(1);

        // Reset in the cycle after an r1 issue kills its response.
        drive(1'b0, '0, '0, '0, 1'b1, 32'd1, 32'd2, 5'd0, 1'b0);
        step();
        reset = 1'b1;
        drive(1'b1, 32'd4, 32'd4, 5'd0, 1'b0, '0, '0, '0, 1'b0);
        step();
        reset = 1'b0;
        idle(2);

        // Back-to-back r1: 2, 4, 6.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, '0, '0, '0, 1'b1, 32'(i), 32'(i), 5'd0, 1'b0);
            step();
        end
        idle(2);

        // Random traffic including flushes.
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 5)),
                  1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 5)),
                  ($urandom_range(0, 3) == 0));
            step();
        end
        idle(2);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter sharing the single execute-stage ALU between the pipeline (requester 0) and a secondary requester (requester 1, e.g. debug/coprocessor path). It issues at most one operation per cycle, drives the ALU operand and control inputs, and routes the registered ALU result and NZCV flags back to the issuing requester. Requester 0 has fixed priority. A starvation counter forces a requester-1 grant after a bounded wait. Pipeline flushes cancel requester-0 operations at issue and in flight.

## Interface
- WIDTH, 32, operand/result width
- CTRL_W, 5, ALU control code width
- STARVE_MAX, 4, consecutive r1 denials before a forced r1 grant (1..15)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- r0_valid / r1_valid  in  1  request valid
- r0_ready / r1_ready  out  1  grant; transfer when valid && ready (combinational)
- r0_a, r0_b / r1_a, r1_b  in  WIDTH  operands
- r0_ctrl / r1_ctrl  in  CTRL_W  ALU control code
- flush  in  1  pipeline flush; cancels requester-0 work only
- alu_a, alu_b  out  WIDTH  ALU operands (combinational from grant)
- alu_ctrl  out  CTRL_W  ALU control code
- alu_result  in  WIDTH  registered ALU result (1-cycle latency)
- alu_flags  in  4  registered {N,Z,C,V}
- r0_rvalid / r1_rvalid  out  1  response pulse to the issuing requester
- rdata  out  WIDTH  shared response data, qualified by rvalid
- rflags  out  4  shared response flags, qualified by rvalid

## Operation
- Grant decision in each cycle, in priority order:
  - force_r1 set and r1_valid → grant r1.
  - r0_valid && !flush → grant r0.
  - r1_valid → grant r1.
  - Otherwise no grant.
- At most one ready is high per cycle. r0_ready is 0 whenever flush=1.
- Operand mux:
  - Granted requester's a/b/ctrl drive alu_a/alu_b/alu_ctrl.
  - No grant → alu_a=0, alu_b=0, alu_ctrl=0 (add).
- Starvation counter starve_cnt (4 bits, registered):
  - Increments when r1_valid=1 and r0 is granted.
  - Clears on any r1 grant.
  - Holds otherwise and saturates at STARVE_MAX.
- force_r1 = (starve_cnt == STARVE_MAX).
  - While r1_valid is low, force_r1 is ignored and r0 can still be granted.
  - Counter holds until the next r1 grant.
- In-flight tracking registers, set from the issue cycle:
  - inflight_v = 1 when a transfer occurs.
  - inflight_id = granted requester index.
- Response cycle (the cycle after issue):
  - inflight_v && inflight_id=0 && !flush → r0_rvalid=1.
  - inflight_v && inflight_id=1 → r1_rvalid=1 (flush is ignored).
  - rdata=alu_result and rflags=alu_flags whenever either rvalid is high. Otherwise rdata=0 and rflags=0.
- There is no response backpressure. Requesters must accept rvalid pulses.
- Control codes pass through unchecked. An undefined code yields whatever the ALU returns.

## Timing
- Issue-to-response latency is exactly 1 cycle. Throughput is 1 op/cycle, sustained for either requester.
- Output reset values:
  - r0_rvalid=0, r1_rvalid=0, rdata=0, rflags=0.
  - starve_cnt=0, inflight_v=0.
  - r0_ready=r1_ready=0 in the reset cycle (grants are gated by reset).
- Reset mid-operation:
  - An op issued in the cycle before reset asserts produces no response.
  - The first post-reset cycle has both rvalid=0.
- Flush and requester-0 responses:
  - Flush in the response cycle of an r0 op suppresses r0_rvalid.
  - Flush in the issue cycle blocks the r0 grant, so r1 can take the slot.
  - The r0 request must be re-presented; r0_valid may stay high.
- Simultaneous events:
  - Response of op N and issue of op N+1 occur in the same cycle with no bubble.
  - A flush suppressing an r0 response does not affect an r1 issue in the same cycle.
- STARVE_MAX boundary with both requesters continuously valid and no flush:
  - Grant pattern is r0 ×STARVE_MAX, then r1 ×1, repeating.

## Test plan
- Basic r0 op: r0 issues 5+7 (ctrl=00000) → r0_ready=1 same cycle; next cycle r0_rvalid=1, rdata=12, rflags=0000, r1_rvalid=0.
- Starvation with STARVE_MAX=4:
  - Stimulus: r0 and r1 continuously valid for 10 cycles.
  - Required grants: r0,r0,r0,r0,r1,r0,r0,r0,r0,r1.
  - Each response appears on the matching rvalid one cycle after its grant.
- Flush in flight: r0 issues 3−3 (ctrl=00001) in cycle N; flush=1 in cycle N+1 → no r0_rvalid in N+1.
- Flush at issue with r1 waiting:
  - Stimulus: cycle N has flush=1, r0_valid=1, r1_valid=1 with 0xF0 & 0x3C.
  - Required: r0_ready=0, r1_ready=1, starve_cnt cleared.
  - Cycle N+1: r1_rvalid=1, rdata=0x30, and flush that cycle does not suppress it.
- Reset mid-operation: r1 issues in cycle N; reset=1 in N+1 → r1_rvalid=0, rdata=0, starve_cnt=0 in N+1 and N+2.
- Back-to-back r1 only: r1 issues 1+1, 2+2, 3+3 on consecutive cycles → r1_rvalid high 3 consecutive cycles with rdata 2, 4, 6.
